vp_conv3x3: RTL and testbench
=============================

# vp_conv3x3

Pipelined 3x3 convolution stage directly downstream of the line-buffer controller. It consumes one 9-pixel window per cycle and applies one of four fixed kernels, selectable per row. It normalises and clips the result and emits one output pixel per input window with a fixed 3-cycle latency. It also flags the last pixel of each row for the downstream frame writer.

## Interface
- DW, 8: pixel width, unsigned.
- RL, 640: windows per row; sets the column counter range.
- i_clk  in  1  clock; all logic rising-edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_pixel_data  in  9*DW  window. Pixel p[k] = bits [k*DW +: DW], with k = 3*r + c. Row r=0 is the oldest/top row; column c=0 is the left pixel.
- i_pixel_valid  in  1  window valid; no backpressure.
- i_kernel_sel  in  2  kernel request: 0 identity, 1 gaussian, 2 sharpen, 3 laplacian.
- o_pixel  out  DW  filtered pixel; reset value 0.
- o_pixel_valid  out  1  output valid; reset value 0.
- o_eol  out  1  high with the output of column RL-1; reset value 0.

## Operation
- Kernels use signed 5-bit coefficients, listed k=0..8, followed by the right shift applied to the sum:
  - identity: 0,0,0,0,1,0,0,0,0; shift 0.
  - gaussian: 1,2,1,2,4,2,1,2,1; shift 4.
  - sharpen: 0,-1,0,-1,5,-1,0,-1,0; shift 0.
  - laplacian: -1,-1,-1,-1,8,-1,-1,-1,-1; shift 0.
- Column counter col (width clog2(RL)):
  - Increments on each valid input.
  - Wraps RL-1 -> 0.
  - Holds while i_pixel_valid is low. Gaps inside a row are legal.
- Kernel register ksel:
  - Loads i_kernel_sel only on a valid input with col==0.
  - Requests arriving mid-row are ignored until the next row starts.
  - The loaded value is used from that same window onward.
- Arithmetic:
  - Each pixel is zero-extended to DW+1 signed and multiplied by its coefficient, giving DW+6 bits.
  - The nine products are summed at DW+10 bits signed; overflow is impossible.
  - The sum is arithmetically right-shifted by the kernel's shift.
- Clip: result < 0 -> 0; result > 2^DW-1 -> 2^DW-1; otherwise pass through.
- Reset at any time:
  - Clears all pipeline valid bits, col, ksel, and the outputs.
  - Windows in flight are dropped and no partial outputs are emitted.
  - The first valid input after reset is treated as col 0.

## Timing
- Stage 1 (S1): register the nine products, ksel, and an eol flag (col==RL-1).
- Stage 2 (S2): register three row partial sums.
- Stage 3 (S3): final sum, shift, and clip, registered into o_pixel.
- Latency: an input valid at cycle n gives o_pixel_valid at cycle n+3. Throughput is 1 per cycle.
- Valid, eol, and ksel travel alongside the data at every stage.
- o_eol is never high while o_pixel_valid is low.
- o_pixel holds its last value while o_pixel_valid is low.
- The input valid pattern is reproduced exactly at the output, shifted by 3 cycles.

## Configuration
- VP_CONV_ABS_EN defined: a negative shifted result is replaced by its absolute value before the upper clip. This gives edge magnitude for sharpen and laplacian.
- VP_CONV_ABS_EN undefined: a negative result clips to 0.
- Identity and gaussian results are identical in both builds.

## Structure
- Package vp_pkg holds:
  - the kernel-select encoding constants KSEL_IDENTITY..KSEL_LAPLACE;
  - the coefficient width (5);
  - the per-kernel shift constants;
  - the sum-width rule DW+10.
- One sub-module, vp_conv_coef_rom: a combinational map from ksel to nine coefficients plus the shift, instantiated once at S1.
- Counter, ksel latch, and pipeline all live in vp_conv3x3.

## Test plan
- Identity, DW=8: one window with p[4]=0x5A and the other pixels 0x11..0x88 -> o_pixel=0x5A, valid exactly 3 cycles later.
- Gaussian: all pixels 100 -> 100. Only p[4]=255, others 0 -> 63.
- Sharpen: only p[4]=255, others 0 -> 255 (clipped). Only p[1],p[3],p[5],p[7]=200, others 0 -> 0 without the macro, 255 with VP_CONV_ABS_EN.
- Row control, RL=640, back-to-back rows:
  - o_eol pulses only with output 639.
  - Switching i_kernel_sel from 0 to 3 at col 100 keeps identity through col 639; laplacian starts at col 0 of the next row.
  - A random 1-in-3 valid gap pattern is reproduced at the output shifted by 3 cycles.
- Reset mid-row: assert i_rstn=0 for one cycle at col 300 with 3 windows in flight.
  - o_pixel_valid=0 from the next cycle.
  - No stale outputs appear afterwards.
  - The next valid input is col 0 and ksel reloads from it.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared constants for the 3x3 convolution stage: kernel-select encoding,
// coefficient width, per-kernel right shifts and the accumulator width rule.
package vp_pkg;

    localparam logic [1:0] KSEL_IDENTITY = 2'd0;
    localparam logic [1:0] KSEL_GAUSS    = 2'd1;
    localparam logic [1:0] KSEL_SHARPEN  = 2'd2;
    localparam logic [1:0] KSEL_LAPLACE  = 2'd3;

    localparam int unsigned COEF_W  = 5;
    localparam int unsigned SHIFT_W = 3;

    localparam logic [SHIFT_W-1:0] SHIFT_IDENTITY = 3'd0;
    localparam logic [SHIFT_W-1:0] SHIFT_GAUSS    = 3'd4;
    localparam logic [SHIFT_W-1:0] SHIFT_SHARPEN  = 3'd0;
    localparam logic [SHIFT_W-1:0] SHIFT_LAPLACE  = 3'd0;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Nine products of DW+6 bits never overflow a DW+10 bit signed sum.
    function automatic int unsigned sum_width(input int unsigned dw);
        return dw + 10;
    endfunction

endpackage

// File: rtl/vp_conv3x3_if.sv
// Window-in / pixel-out bundle of the 3x3 convolution stage.
// master drives the windows, slave is the convolution stage.
interface vp_conv3x3_if #(
    parameter int unsigned DW = 8
);
    logic [9*DW-1:0] i_pixel_data;
    logic            i_pixel_valid;
    logic [1:0]      i_kernel_sel;
    logic [DW-1:0]   o_pixel;
    logic            o_pixel_valid;
    logic            o_eol;

    modport master (
        output i_pixel_data, i_pixel_valid, i_kernel_sel,
        input  o_pixel, o_pixel_valid, o_eol
    );

    modport slave (
        input  i_pixel_data, i_pixel_valid, i_kernel_sel,
        output o_pixel, o_pixel_valid, o_eol
    );
endinterface

// File: rtl/vp_conv_coef_rom.sv
// Combinational kernel table: maps a kernel select to its nine signed
// coefficients (k = 3*row + col) and the right shift applied to the sum.
module vp_conv_coef_rom
    import vp_pkg::*;
(
    input  logic [1:0]         ksel,
    output coef_t              coef [9],
    output logic [SHIFT_W-1:0] shift
);

    logic [9*COEF_W-1:0] flat;

    function automatic logic [9*COEF_W-1:0] pack9(
        input int c0, input int c1, input int c2,
        input int c3, input int c4, input int c5,
        input int c6, input int c7, input int c8
    );
        return {COEF_W'(c8), COEF_W'(c7), COEF_W'(c6),
                COEF_W'(c5), COEF_W'(c4), COEF_W'(c3),
                COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
    endfunction

    always_comb begin
        flat  = '0;
        shift = SHIFT_IDENTITY;
        unique case (ksel)
            KSEL_IDENTITY: begin
                flat  = pack9(0, 0, 0, 0, 1, 0, 0, 0, 0);
                shift = SHIFT_IDENTITY;
            end
            KSEL_GAUSS: begin
                flat  = pack9(1, 2, 1, 2, 4, 2, 1, 2, 1);
                shift = SHIFT_GAUSS;
            end
            KSEL_SHARPEN: begin
                flat  = pack9(0, -1, 0, -1, 5, -1, 0, -1, 0);
                shift = SHIFT_SHARPEN;
            end
            KSEL_LAPLACE: begin
                flat  = pack9(-1, -1, -1, -1, 8, -1, -1, -1, -1);
                shift = SHIFT_LAPLACE;
            end
            default: begin
                flat  = '0;
                shift = SHIFT_IDENTITY;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            coef[k] = coef_t'(flat[k*COEF_W +: COEF_W]);
        end
    end

endmodule

// File: rtl/vp_conv3x3.sv
// Three-stage pipelined 3x3 convolution with per-row kernel selection,
// normalising shift and clip to DW bits. Define VP_CONV_ABS_EN to output
// the magnitude of negative results instead of clipping them to zero.
module vp_conv3x3
    import vp_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned RL = 640
) (
    input logic         i_clk,
    input logic         i_rstn,
    vp_conv3x3_if.slave bus
);

    localparam int unsigned CW = (RL > 1) ? $clog2(RL) : 1;
    localparam int unsigned PW = DW + 6;
    localparam int unsigned SW = sum_width(DW);
    localparam logic [CW-1:0] COL_LAST = CW'(RL - 1);
    localparam logic signed [SW-1:0] PIX_MAX = SW'((2 ** DW) - 1);

    // Row position and kernel latch
    logic [CW-1:0] col_q;
    logic [1:0]    ksel_q;
    logic [1:0]    ksel_eff;
    logic          row_start;

    assign row_start = bus.i_pixel_valid && (col_q == '0);
    // A request at col 0 takes effect on that same window.
    assign ksel_eff  = row_start ? bus.i_kernel_sel : ksel_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            col_q  <= '0;
            ksel_q <= KSEL_IDENTITY;
        end else if (bus.i_pixel_valid) begin
            col_q  <= (col_q == COL_LAST) ? '0 : col_q + CW'(1);
            ksel_q <= ksel_eff;
        end
    end

    // S1: products
    coef_t              coef [9];
    logic [SHIFT_W-1:0] shift;

    vp_conv_coef_rom u_coef_rom (
        .ksel  (ksel_eff),
        .coef  (coef),
        .shift (shift)
    );

    logic signed [PW-1:0] prod [9];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            prod[k] = $signed(PW'({1'b0, bus.i_pixel_data[k*DW +: DW]})) * PW'(coef[k]);
        end
    end

    logic                 s1_valid_q;
    logic                 s1_eol_q;
    logic [SHIFT_W-1:0]   s1_shift_q;
    logic signed [PW-1:0] s1_prod_q [9];

    logic                 s2_valid_q;
    logic                 s2_eol_q;
    logic [SHIFT_W-1:0]   s2_shift_q;
    logic signed [SW-1:0] s2_row_q [3];

    // Only the valid bits need reset; data stages load on valid only.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.i_pixel_valid;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (bus.i_pixel_valid) begin
            s1_eol_q   <= (col_q == COL_LAST);
            s1_shift_q <= shift;
            for (int k = 0; k < 9; k++) begin
                s1_prod_q[k] <= prod[k];
            end
        end
        if (s1_valid_q) begin
            s2_eol_q   <= s1_eol_q;
            s2_shift_q <= s1_shift_q;
            for (int r = 0; r < 3; r++) begin
                s2_row_q[r] <= SW'(s1_prod_q[3*r]) + SW'(s1_prod_q[3*r+1])
                             + SW'(s1_prod_q[3*r+2]);
            end
        end
    end

    // S3: final sum, normalise, clip
    logic signed [SW-1:0] total;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] mag;
    logic [DW-1:0]        pix_d;

    always_comb begin
        total   = s2_row_q[0] + s2_row_q[1] + s2_row_q[2];
        shifted = total >>> s2_shift_q;
`ifdef VP_CONV_ABS_EN
        mag     = (shifted < 0) ? -shifted : shifted;
`else
        mag     = (shifted < 0) ? '0 : shifted;
`endif
        if (mag > PIX_MAX) begin
            pix_d = '1;
        end else begin
            pix_d = mag[DW-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            bus.o_pixel       <= '0;
            bus.o_pixel_valid <= 1'b0;
            bus.o_eol         <= 1'b0;
        end else begin
            bus.o_pixel_valid <= s2_valid_q;
            bus.o_eol         <= s2_valid_q & s2_eol_q;
            if (s2_valid_q) begin
                bus.o_pixel <= pix_d;
            end
        end
    end

endmodule

// File: tb/tb_vp_conv3x3.sv
// Directed bench for vp_conv3x3: per-kernel windows, row/eol/kernel latching,
// valid gaps and mid-row reset, checked cycle by cycle against an expect queue.
module tb_vp_conv3x3;

    localparam int unsigned DW = 8;
    localparam int unsigned RL = 640;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    vp_conv3x3_if #(.DW(DW)) bus ();

    vp_conv3x3 #(.DW(DW), .RL(RL)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic       valid;
        logic       eol;
        logic [7:0] pix;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         col_m = 0;
    logic [1:0] ksel_m = 2'd0;
    logic [7:0] last_p = 8'd0;

`ifdef VP_CONV_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9*DW-1:0] win9(
        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
        input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
        input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8
    );
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic logic [9*DW-1:0] center(input logic [7:0] v);
        return win9(8'd0, 8'd0, 8'd0, 8'd0, v, 8'd0, 8'd0, 8'd0, 8'd0);
    endfunction

    // Expected output for a centre-only window of value v.
    function automatic logic [7:0] model(input logic [1:0] k, input logic [7:0] v);
        int r;
        case (k)
            2'd0:    r = int'(v);
            2'd1:    r = (4 * int'(v)) >> 4;
            2'd2:    r = 5 * int'(v);
            default: r = 8 * int'(v);
        endcase
        return (r > 255) ? 8'hFF : r[7:0];
    endfunction

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL queue observed=empty expected=entry");
            return;
        end
        e = q.pop_front();
        if (e.valid) last_p = e.pix;
        check("valid", {31'd0, bus.o_pixel_valid}, {31'd0, e.valid});
        check("eol",   {31'd0, bus.o_eol},         {31'd0, e.eol});
        check("pixel", {24'd0, bus.o_pixel},       {24'd0, last_p});
    endtask

    task automatic drive(input logic v, input logic [9*DW-1:0] data,
                         input logic [1:0] ks, input logic [7:0] exp_p);
        exp_t e;
        bus.i_pixel_valid = v;
        bus.i_pixel_data  = data;
        bus.i_kernel_sel  = ks;
        e.valid = v;
        e.eol   = v && (col_m == int'(RL) - 1);
        e.pix   = exp_p;
        if (v) col_m = (col_m == int'(RL) - 1) ? 0 : col_m + 1;
        q.push_back(e);
        tick();
        pop_check();
    endtask

    task automatic drive_c(input logic v, input logic [7:0] cv, input logic [1:0] ks);
        if (v && col_m == 0) ksel_m = ks;
        drive(v, center(cv), ks, model(ksel_m, cv));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 72'({$urandom, $urandom, $urandom}), 2'($urandom), 8'd0);
        end
    endtask

    task automatic do_reset(input int n, input logic v);
        exp_t e;
        rstn = 1'b0;
        bus.i_pixel_valid = v;
        bus.i_pixel_data  = center(8'd9);
        bus.i_kernel_sel  = 2'($urandom);
        for (int i = 0; i < n; i++) tick();
        check("rst_valid", {31'd0, bus.o_pixel_valid}, 32'd0);
        check("rst_eol",   {31'd0, bus.o_eol},         32'd0);
        check("rst_pixel", {24'd0, bus.o_pixel},       32'd0);
        rstn = 1'b1;
        q.delete();
        e.valid = 1'b0;
        e.eol   = 1'b0;
        e.pix   = 8'd0;
        q.push_back(e);
        q.push_back(e);
        col_m  = 0;
        ksel_m = 2'd0;
        last_p = 8'd0;
    endtask

    function automatic logic [7:0] rv(input int c);
        return 8'((c % 31) + 1);
    endfunction

    initial begin
        int c;
        bus.i_pixel_valid = 1'b0;
        bus.i_pixel_data  = '0;
        bus.i_kernel_sel  = 2'd0;

        do_reset(2, 1'b0);

        // Identity: neighbours must not leak into the result
        drive(1'b1, win9(8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h55, 8'h66, 8'h77, 8'h88),
              2'd0, 8'h5A);
        idle(4);

        // Gaussian
        do_reset(1, 1'b0);
        drive(1'b1, {9{8'd100}}, 2'd1, 8'd100);
        drive(1'b1, center(8'd255), 2'd0, 8'd63);
        idle(3);

        // Sharpen
        do_reset(1, 1'b0);
        drive(1'b1, center(8'd255), 2'd2, 8'd255);
        drive(1'b1, win9(8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0),
              2'd1, ABS ? 8'd255 : 8'd0);
        drive(1'b1, win9(8'd0, 8'd10, 8'd0, 8'd20, 8'd60, 8'd30, 8'd0, 8'd40, 8'd0),
              2'd0, 8'd200);
        idle(3);

        // Laplacian
        do_reset(1, 1'b0);
        drive(1'b1, win9(8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),
              2'd3, ABS ? 8'd10 : 8'd0);
        drive(1'b1, center(8'd50), 2'd3, 8'd255);
        drive(1'b1, {9{8'd77}}, 2'd3, 8'd0);
        drive(1'b1, win9(8'd1, 8'd2, 8'd3, 8'd4, 8'd20, 8'd5, 8'd6, 8'd7, 8'd8),
              2'd3, 8'd124);
        idle(3);

        // Row A: kernel request changes mid-row and must be ignored
        do_reset(1, 1'b0);
        for (int i = 0; i < int'(RL); i++) begin
            drive_c(1'b1, rv(i), (i < 100) ? 2'd0 : 2'd3);
        end
        // Row B: laplacian from col 0, random mid-row requests, 1-in-3 gaps
        c = 0;
        while (c < int'(RL)) begin
            if ($urandom_range(0, 2) == 0) begin
                drive_c(1'b0, 8'($urandom), 2'($urandom));
            end else begin
                drive_c(1'b1, rv(c), (c == 0) ? 2'd3 : 2'($urandom));
                c++;
            end
        end
        // Row C: sharpen, reset hits at col 300 with three windows in flight
        for (int i = 0; i < 300; i++) begin
            drive_c(1'b1, rv(i), (i == 0) ? 2'd2 : 2'($urandom));
        end
        do_reset(1, 1'b1);
        // Row D: restarts at col 0 with a fresh kernel load
        for (int i = 0; i < int'(RL); i++) begin
            drive_c(1'b1, rv(i + 7), (i == 0) ? 2'd1 : 2'($urandom));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
